// File: rtl/muffer_seq_ctrl.sv
// muffer_seq_ctrl: circular-window sequencer driving one Muffer scratchpad.
// Optional stall statistics counter: define MUFFER_SEQ_STALL_STATS_EN.
module muffer_seq_ctrl #(
    parameter int DEPTH         = 16,
    parameter int PAR_WRITE     = 1,
    parameter int PAR_READ      = 1,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int STRIDE_WIDTH  = 4,
    parameter int WIN_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [STRIDE_WIDTH-1:0]  cfg_stride,
    input  logic [WIN_CNT_WIDTH-1:0] cfg_num_win,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH:0]      occupancy,
    output logic                     mf_write_en,
    output logic [ADDR_WIDTH-1:0]    mf_write_addr,
    output logic [ADDR_WIDTH-1:0]    mf_read_addr,
    output logic [15:0]              stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int OW = ADDR_WIDTH + 1;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]            occ_q, occ_d;
    logic [WIN_CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_CNT_WIDTH-1:0] num_win_q, num_win_d;
    logic [STRIDE_WIDTH-1:0]  stride_q, stride_d;

    logic        run;
    logic        accept;
    logic        take;
    logic [31:0] occ_w;
    logic [31:0] stride_w;
    logic [31:0] need_w;

    // stride_q and num_win_q hold the effective (zero-mapped-to-one) values
    assign run      = (state_q == S_RUN);
    assign occ_w    = 32'(occ_q);
    assign stride_w = 32'(stride_q);
    assign need_w   = (stride_w > 32'(PAR_READ)) ? stride_w : 32'(PAR_READ);

    assign in_ready  = run && ((occ_w + 32'(PAR_WRITE)) <= 32'(DEPTH));
    assign win_valid = run && (occ_w >= need_w);
    assign accept    = in_valid && in_ready;
    assign take      = win_valid && win_ready;

    assign mf_write_en   = accept;
    assign mf_write_addr = wr_ptr_q;
    assign mf_read_addr  = rd_ptr_q;
    assign occupancy     = occ_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        win_cnt_d = win_cnt_q;
        num_win_d = num_win_q;
        stride_d  = stride_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    occ_d     = '0;
                    win_cnt_d = '0;
                    stride_d  = (cfg_stride == '0)
                              ? STRIDE_WIDTH'(1) : cfg_stride;
                    num_win_d = (cfg_num_win == '0)
                              ? WIN_CNT_WIDTH'(1) : cfg_num_win;
                end
            end
            S_RUN: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(PAR_WRITE);
                end
                if (take) begin
                    rd_ptr_d  = ADDR_WIDTH'(32'(rd_ptr_q) + stride_w);
                    win_cnt_d = win_cnt_q + WIN_CNT_WIDTH'(1);
                    if (win_cnt_q == (num_win_q - WIN_CNT_WIDTH'(1))) begin
                        state_d = S_DONE;
                    end
                end
                occ_d = OW'(occ_w
                      + (accept ? 32'(PAR_WRITE) : 32'd0)
                      - (take ? stride_w : 32'd0));
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            win_cnt_q <= '0;
            num_win_q <= WIN_CNT_WIDTH'(1);
            stride_q  <= STRIDE_WIDTH'(1);
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            win_cnt_q <= win_cnt_d;
            num_win_q <= num_win_d;
            stride_q  <= stride_d;
        end
    end

`ifdef MUFFER_SEQ_STALL_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if (run && in_valid && !win_valid
                     && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule
